// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg: state encoding, datapath mux encodings and opcodes for the multicycle ARM control FSM
package arm_mc_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
    } state_t;
    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_ALUOUT    = 1'b1;
    localparam logic [1:0] SRCA_RN       = 2'b00;
    localparam logic [1:0] SRCA_PC       = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT   = 2'b10;
    localparam logic [1:0] SRCB_RM       = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] OP_DP         = 2'b00;
    localparam logic [1:0] OP_MEM        = 2'b01;
    localparam logic [1:0] OP_BR         = 2'b10;
endpackage

// File: rtl/arm_mc_main_fsm.sv
// arm_mc_main_fsm: multicycle ARM main sequencer with memory-ready stalls and retired-instruction counter
module arm_mc_main_fsm
    import arm_mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             NextPC,
    output logic             AdrSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             ALUOp,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic             illegal,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             ir_w, pc_w, reg_w, mem_w;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (instr_done) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_w       = 1'b0;
        pc_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        AdrSrc     = ADR_PC;
        ALUSrcA    = SRCA_RN;
        ALUSrcB    = SRCB_RM;
        ResultSrc  = RES_ALUOUT;
        ALUOp      = 1'b0;
        Branch     = 1'b0;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ir_w      = mem_ready;
                pc_w      = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (Op)
                    OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    default: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = ADR_ALUOUT;
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                reg_w      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = ADR_ALUOUT;
                mem_w      = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                ALUOp   = 1'b1;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                ALUOp   = 1'b1;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_ALUOUT;
                ALUSrcB    = SRCB_IMM;
                ResultSrc  = RES_ALURESULT;
                Branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Write enables are held off during reset so an abandoned instruction cannot commit.
    assign IRWrite     = ir_w & reset_n;
    assign NextPC      = pc_w & reset_n;
    assign RegW        = reg_w & reset_n;
    assign MemW        = mem_w & reset_n;
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_arm_mc_main_fsm.sv
// tb_arm_mc_main_fsm: directed-vector check of the multicycle ARM main FSM outputs and counter
module tb_arm_mc_main_fsm;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic        mem_ready;
    logic        IRWrite, NextPC, AdrSrc, ALUOp, RegW, MemW, Branch, illegal, instr_done;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic [31:0] instr_count;
    logic        w_ir, w_pc, w_adr, w_aluop, w_regw, w_memw, w_br, w_ill, w_done;
    logic [1:0]  w_a, w_b, w_res;
    logic [1:0]  cnt2;
    logic [14:0] outs;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    arm_mc_main_fsm dut (
        .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .illegal(illegal), .instr_done(instr_done),
        .instr_count(instr_count)
    );

    arm_mc_main_fsm #(.CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
        .IRWrite(w_ir), .NextPC(w_pc), .AdrSrc(w_adr), .ALUSrcA(w_a),
        .ALUSrcB(w_b), .ResultSrc(w_res), .ALUOp(w_aluop), .RegW(w_regw),
        .MemW(w_memw), .Branch(w_br), .illegal(w_ill), .instr_done(w_done),
        .instr_count(cnt2)
    );

    assign outs = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                   ALUOp, RegW, MemW, Branch, illegal, instr_done};

    // {IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,RegW,MemW,Branch,illegal,instr_done}
    localparam logic [14:0] F0   = 15'b0_0_0_01_10_10_0_0_0_0_0_0;
    localparam logic [14:0] F1   = 15'b1_1_0_01_10_10_0_0_0_0_0_0;
    localparam logic [14:0] DEC  = 15'b0_0_0_01_10_10_0_0_0_0_0_0;
    localparam logic [14:0] DILL = 15'b0_0_0_01_10_10_0_0_0_0_1_1;
    localparam logic [14:0] MADR = 15'b0_0_0_00_01_00_0_0_0_0_0_0;
    localparam logic [14:0] MRD  = 15'b0_0_1_00_00_00_0_0_0_0_0_0;
    localparam logic [14:0] MWB  = 15'b0_0_0_00_00_01_0_1_0_0_0_1;
    localparam logic [14:0] MWR0 = 15'b0_0_1_00_00_00_0_0_1_0_0_0;
    localparam logic [14:0] MWR1 = 15'b0_0_1_00_00_00_0_0_1_0_0_1;
    localparam logic [14:0] EXR  = 15'b0_0_0_00_00_00_1_0_0_0_0_0;
    localparam logic [14:0] EXI  = 15'b0_0_0_00_01_00_1_0_0_0_0_0;
    localparam logic [14:0] AWB  = 15'b0_0_0_00_00_00_0_1_0_0_0_1;
    localparam logic [14:0] BR   = 15'b0_0_0_10_01_10_0_0_0_1_0_1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic mr, input logic [14:0] exp);
        mem_ready = mr;
        @(negedge clk);
        chk(tag, {17'd0, outs}, {17'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; Op = 2'b00; Funct = 6'b001000; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_outs", {17'd0, outs}, {17'd0, F0});
        chk("reset_cnt", instr_count, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc("add_fetch", 1, F1);
        cyc("add_dec", 1, DEC);
        cyc("add_exr", 1, EXR);
        cyc("add_wb", 1, AWB);
        chk("add_cnt", instr_count, 32'd1);
        Funct = 6'b101000;
        cyc("addi_fetch", 1, F1);
        cyc("addi_dec_mr0", 0, DEC);
        cyc("addi_exi", 0, EXI);
        cyc("addi_wb", 0, AWB);
        chk("addi_cnt", instr_count, 32'd2);
        Op = 2'b01; Funct = 6'b000001;
        cyc("ldr_fetch", 1, F1);
        cyc("ldr_dec", 1, DEC);
        cyc("ldr_madr", 1, MADR);
        cyc("ldr_rd_w1", 0, MRD);
        cyc("ldr_rd_w2", 0, MRD);
        cyc("ldr_rd", 1, MRD);
        cyc("ldr_wb", 1, MWB);
        chk("ldr_cnt", instr_count, 32'd3);
        Funct = 6'b000000;
        cyc("str_stall1", 0, F0);
        cyc("str_stall2", 0, F0);
        cyc("str_fetch", 1, F1);
        cyc("str_dec", 1, DEC);
        cyc("str_madr", 1, MADR);
        cyc("str_wr_w1", 0, MWR0);
        cyc("str_wr_w2", 0, MWR0);
        cyc("str_wr_exit", 1, MWR1);
        chk("str_cnt", instr_count, 32'd4);
        chk("wrap_cnt2", {30'd0, cnt2}, 32'd0);
        Op = 2'b10;
        cyc("br_fetch", 1, F1);
        cyc("br_dec", 1, DEC);
        cyc("br_exec", 1, BR);
        cyc("br_back_fetch", 1, F1);
        chk("br_cnt", instr_count, 32'd5);
        Op = 2'b11;
        cyc("ill_dec", 1, DILL);
        chk("ill_cnt", instr_count, 32'd6);
        cyc("ill_fetch", 1, F1);
        Op = 2'b01; Funct = 6'b000001;
        cyc("rst_dec", 1, DEC);
        cyc("rst_madr", 1, MADR);
        cyc("rst_rd_wait", 0, MRD);
        reset_n = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_mid_outs", {17'd0, outs}, {17'd0, F0});
        chk("rst_mid_cnt", instr_count, 32'd0);
        chk("rst_mid_cnt2", {30'd0, cnt2}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        Op = 2'b00; Funct = 6'b001000;
        cyc("post_fetch", 1, F1);
        cyc("post_dec", 1, DEC);
        cyc("post_exr", 1, EXR);
        cyc("post_wb", 1, AWB);
        chk("post_cnt", instr_count, 32'd1);
        chk("post_cnt2", {30'd0, cnt2}, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/arm_mc_main_fsm.md
# arm_mc_main_fsm

Main sequencing FSM for the multicycle ARM datapath. Each cycle it decides which datapath sources and write enables are active, and it drives `ALUOp` into `ALU_decoder`. It advances the instruction through fetch, decode, execute, memory and writeback steps. It stalls on a memory-ready handshake and counts retired instructions. Downstream conditional-execution logic gates `RegW`, `MemW` and `Branch`; this block does not evaluate condition codes.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `Op`  in  2  Instr[27:26]: 00 DP, 01 memory, 10 branch, 11 illegal.
- `Funct`  in  6  Instr[25:20]; bit 5 = I (immediate), bit 0 = S for DP, L for memory.
- `mem_ready`  in  1  memory has completed the current access this cycle.
- `IRWrite`  out  1  load instruction register.
- `NextPC`  out  1  PC update enable (pre-condition-gating).
- `AdrSrc`  out  1  0 = PC, 1 = ALU result register.
- `ALUSrcA`  out  2  00 = Rn, 01 = PC, 10 = ALUOut.
- `ALUSrcB`  out  2  00 = Rm, 01 = ExtImm, 10 = constant 4.
- `ResultSrc`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUOp`  out  1  1 = DP execute (ALU_decoder decodes Funct), 0 = add.
- `RegW`  out  1  register write request.
- `MemW`  out  1  memory write request.
- `Branch`  out  1  branch request.
- `illegal`  out  1  one-cycle pulse when DECODE sees Op = 11.
- `instr_done`  out  1  one-cycle pulse on the last cycle of each instruction.
- `instr_count`  out  CNT_W  retired-instruction count.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Outputs not listed for a state are 0. Src fields are 00 unless stated.
- **FETCH:**
  - Drives AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - IRWrite and NextPC are asserted only in the cycle where `mem_ready`=1.
  - Holds while `mem_ready`=0. Goes to DECODE on `mem_ready`=1.
- **DECODE:**
  - Drives ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - Op=00 goes to EXECUTEI if Funct[5]=1, otherwise EXECUTER.
  - Op=01 goes to MEMADR. Op=10 goes to BRANCH.
  - Op=11 pulses `illegal` and `instr_done`, then goes to FETCH.
- **MEMADR:** drives ALUSrcB=01. Goes to MEMREAD if Funct[0]=1, otherwise MEMWRITE.
- **MEMREAD:** drives AdrSrc=1. Holds until `mem_ready`=1, then goes to MEMWB.
- **MEMWB:** drives ResultSrc=01 and RegW. Goes to FETCH.
- **MEMWRITE:**
  - Drives AdrSrc=1 and MemW.
  - MemW stays asserted for every wait cycle.
  - On `mem_ready`=1, leaves to FETCH and marks the instruction complete.
- **EXECUTER:** drives ALUSrcB=00 and ALUOp=1. Goes to ALUWB.
- **EXECUTEI:** drives ALUSrcB=01 and ALUOp=1. Goes to ALUWB.
- **ALUWB:** drives RegW. Goes to FETCH. CMP suppression is handled via NoWrite downstream.
- **BRANCH:** drives ALUSrcA=10, ALUSrcB=01, ResultSrc=10 and Branch. Goes to FETCH.
- **Completion:** `instr_done`=1 in MEMWB, ALUWB, BRANCH, in the MEMWRITE exit cycle, and in the illegal DECODE cycle.
- **Counter:** `instr_count` increments by 1 on every `instr_done` and wraps modulo 2^CNT_W.

## Timing
- Reset (`reset_n`=0 at a rising edge):
  - state becomes FETCH and `instr_count` becomes 0. This applies mid-instruction as well; any in-flight instruction is abandoned.
  - During reset the outputs show FETCH decode values. IRWrite, NextPC, MemW and RegW are forced to 0 while `reset_n`=0.
- Outputs are combinational from the state register, plus `mem_ready` qualification in FETCH and MEMWRITE. They carry no registered delay.
- `instr_count` updates on the edge following the `instr_done` cycle.
- Latency with `mem_ready` tied high:
  - Branch: 3 cycles.
  - DP: 4 cycles.
  - STR: 4 cycles.
  - LDR: 5 cycles.
  - Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `mem_ready` is sampled only in FETCH, MEMREAD and MEMWRITE; it is ignored in all other states.
- `Op` and `Funct` are sampled only in DECODE and MEMADR. They must be stable from the IR from DECODE onward.

## Structure
- Package `arm_mc_pkg` contains:
  - `state_t` enum.
  - Localparams for the AdrSrc, ALUSrcA, ALUSrcB and ResultSrc encodings.
  - Op codes OP_DP=2'b00, OP_MEM=2'b01, OP_BR=2'b10.
- No sub-module. The state register, next-state logic, output decode and counter live in one module.

## Test plan
- **ADD reg, mem_ready=1:** Op=00, Funct=6'b001000 → state sequence FETCH, DECODE, EXECUTER, ALUWB, FETCH. ALUOp=1 only in EXECUTER; RegW=1 only in ALUWB; `instr_count` goes 0→1.
- **LDR with 2 wait cycles in MEMREAD:** Op=01, Funct[0]=1 → state sequence FETCH, DECODE, MEMADR, MEMREAD×3, MEMWB. ResultSrc=01 and RegW=1 in MEMWB; total 7 cycles.
- **STR with FETCH stall:** `mem_ready`=0 for 2 cycles in FETCH → IRWrite=0 during the stall and IRWrite=1 for exactly one cycle. MemW=1 in MEMWRITE; `instr_done` fires on its exit.
- **Branch:** Op=10 → BRANCH with ALUSrcA=10, ALUSrcB=01 and Branch=1. Return to FETCH after 3 cycles.
- **Illegal opcode:** Op=11 → `illegal`=1 in DECODE, next state FETCH, `instr_count` increments.
- **Reset mid-instruction:** drive `reset_n`=0 during MEMREAD → state is FETCH and `instr_count`=0 after the edge, and no RegW is issued. A counter preloaded to all-ones wraps to 0 on the next `instr_done`.
